// File: rtl/stepdir_ramp_pkg.sv
// Shared types and helpers for the step/dir velocity ramp and its tick divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package stepdir_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ramp_state_t;

    // Counter width for a 0..div-1 counter; never narrower than one bit.
    function automatic int unsigned tick_cnt_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/ramp_tick_div.sv
// Free-running divider: one-cycle tick every UPDATE_DIV clocks (every clock when UPDATE_DIV=1).
// Latency: first tick UPDATE_DIV cycles after reset release.
// Backpressure: none; the tick is a pure strobe.
module ramp_tick_div
    import stepdir_ramp_pkg::*;
#(
    parameter int unsigned UPDATE_DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned    CW   = tick_cnt_width(UPDATE_DIV);
    localparam logic [CW-1:0]  LAST = CW'(UPDATE_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..UPDATE_DIV-1 and wrap; the tick marks the wrapping cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stepdir_velocity_ramp.sv
// Rate-limits the host velocity setpoint/enable before it reaches the step generator.
// Latency: a latched target moves velocity on the first tick after the sync (<= UPDATE_DIV+1 clocks).
// Backpressure: none; inputs are sampled on sync, outputs are levels.
module stepdir_velocity_ramp
    import stepdir_ramp_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      UPDATE_DIV = 27000,
    parameter logic [WIDTH-1:0] ACCEL      = WIDTH'(2000),
    parameter logic [WIDTH-1:0] ERR_ACCEL  = WIDTH'(20000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] target,
    input  logic                    enable,
    input  logic                    error,
    input  logic                    sync,
    output logic signed [WIDTH-1:0] velocity,
    output logic                    en_out,
    output logic                    at_target,
    output logic                    ramping
);

    logic signed [WIDTH-1:0] tgt_l;
    logic                    en_l;
    logic                    error_q;
    logic                    tick;
    ramp_state_t             state;

    logic                    run_ok;
    logic signed [WIDTH-1:0] eff;
    logic        [WIDTH-1:0] lim;
    logic signed [WIDTH:0]   diff;
    logic        [WIDTH:0]   diff_mag;
    logic signed [WIDTH-1:0] vel_step;

    ramp_tick_div #(
        .UPDATE_DIV (UPDATE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Error forces the effective target to zero and widens the per-tick step.
    assign run_ok = en_l & ~error;
    assign eff    = run_ok ? tgt_l : '0;
    assign lim    = error ? ERR_ACCEL : ACCEL;

    // One extra bit keeps eff - velocity exact even across the full signed range.
    assign diff     = {eff[WIDTH-1], eff} - {velocity[WIDTH-1], velocity};
    assign diff_mag = diff[WIDTH] ? (~diff + {{WIDTH{1'b0}}, 1'b1}) : diff;

    // Land exactly when within one step, otherwise move one step toward eff (never past it).
    always_comb begin
        vel_step = velocity;
        if (diff_mag <= {1'b0, lim}) begin
            vel_step = eff;
        end else if (diff[WIDTH]) begin
            vel_step = velocity - $signed(lim);
        end else begin
            vel_step = velocity + $signed(lim);
        end
    end

    // Host frame latch; a rising error drops the held enable so clearing error alone never restarts
    // motion, while a sync during error re-arms it for when error clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_l   <= '0;
            en_l    <= 1'b0;
            error_q <= 1'b0;
        end else begin
            error_q <= error;
            if (sync) begin
                tgt_l <= target;
                en_l  <= enable;
            end else if (error && !error_q) begin
                en_l <= 1'b0;
            end
        end
    end

    // Velocity only moves on update ticks. In IDLE eff is zero unless the axis is leaving IDLE
    // on this same edge, so velocity is held at zero there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            velocity <= '0;
        end else if (tick) begin
            velocity <= vel_step;
        end
    end

    // Axis state; en_out follows state transitions only, so it drops after velocity has reached zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            en_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_ok) begin
                        state  <= RUN;
                        en_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run_ok) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (run_ok) begin
                        state <= RUN;
                    end else if (velocity == '0) begin
                        state  <= IDLE;
                        en_out <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    en_out <= 1'b0;
                end
            endcase
        end
    end

    assign at_target = (velocity == eff);
    assign ramping   = ~at_target;

endmodule

// File: tb/tb_stepdir_velocity_ramp.sv
// Bench for stepdir_velocity_ramp: expected output changes are queued with the stimulus,
// a negedge monitor pops one record per observed change of {velocity, en_out, at_target}.
// A second instance with UPDATE_DIV=1 and huge steps covers the signed-range extremes.
module tb_stepdir_velocity_ramp;

    typedef struct packed {
        logic [31:0] vel;
        logic        en;
        logic        at;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic signed [31:0] tgt  = '0;
    logic               en   = 1'b0;
    logic               err  = 1'b0;
    logic               syn  = 1'b0;
    logic signed [31:0] vel;
    logic               eno, at, rmp;

    logic signed [31:0] tgt_x = '0;
    logic               en_x  = 1'b0;
    logic               syn_x = 1'b0;
    logic signed [31:0] vel_x;
    logic               eno_x, at_x, rmp_x;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    obs_t  exp_q[$];
    string tag_q[$];
    obs_t  exp_x[$];
    string tag_xq[$];
    obs_t  prev_m = {32'd0, 1'b0, 1'b1};
    obs_t  prev_x = {32'd0, 1'b0, 1'b1};
    obs_t  cur_m, cur_x;

    always #5 clk = ~clk;

    stepdir_velocity_ramp #(
        .WIDTH      (32),
        .UPDATE_DIV (4),
        .ACCEL      (32'd10),
        .ERR_ACCEL  (32'd50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .target    (tgt),
        .enable    (en),
        .error     (err),
        .sync      (syn),
        .velocity  (vel),
        .en_out    (eno),
        .at_target (at),
        .ramping   (rmp)
    );

    stepdir_velocity_ramp #(
        .WIDTH      (32),
        .UPDATE_DIV (1),
        .ACCEL      (32'h4000_0000),
        .ERR_ACCEL  (32'h4000_0000)
    ) dut_x (
        .clk       (clk),
        .rst       (rst),
        .target    (tgt_x),
        .enable    (en_x),
        .error     (1'b0),
        .sync      (syn_x),
        .velocity  (vel_x),
        .en_out    (eno_x),
        .at_target (at_x),
        .ramping   (rmp_x)
    );

    // Bench copy of the tick phase: edges since reset release; ticks land where cyc % 4 == 0.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input obs_t act, input logic act_rmp, input obs_t req);
        total++;
        if (act !== req || act_rmp !== ~req.at) begin
            bad++;
            $display("FAIL %s: got vel=%0d en=%0d at=%0d ramp=%0d, want vel=%0d en=%0d at=%0d ramp=%0d",
                     tag, $signed(act.vel), act.en, act.at, act_rmp,
                     $signed(req.vel), req.en, req.at, ~req.at);
        end
    endtask

    task automatic expect_m(input logic [31:0] v, input logic e, input logic a, input string t);
        obs_t o;
        o.vel = v; o.en = e; o.at = a;
        exp_q.push_back(o);
        tag_q.push_back(t);
    endtask

    task automatic expect_x(input logic [31:0] v, input logic e, input logic a, input string t);
        obs_t o;
        o.vel = v; o.en = e; o.at = a;
        exp_x.push_back(o);
        tag_xq.push_back(t);
    endtask

    // Monitor for the main instance: every change of the observed outputs consumes one record.
    always @(negedge clk) begin
        cur_m = {vel, eno, at};
        if (cur_m !== prev_m) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_change: got vel=%0d en=%0d at=%0d, want no change",
                         $signed(vel), eno, at);
            end else begin
                check(tag_q.pop_front(), cur_m, rmp, exp_q.pop_front());
            end
            prev_m = cur_m;
        end
    end

    // Monitor for the extremes instance.
    always @(negedge clk) begin
        cur_x = {vel_x, eno_x, at_x};
        if (cur_x !== prev_x) begin
            if (exp_x.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_change_x: got vel=%0d en=%0d at=%0d, want no change",
                         $signed(vel_x), eno_x, at_x);
            end else begin
                check(tag_xq.pop_front(), cur_x, rmp_x, exp_x.pop_front());
            end
            prev_x = cur_x;
        end
    end

    task automatic drain_m(input int budget, input string t);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: pending=%0d, want 0", t, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    task automatic drain_x(input int budget, input string t);
        int n = 0;
        while (exp_x.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_x.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: pending=%0d, want 0", t, exp_x.size());
            exp_x.delete();
            tag_xq.delete();
        end
    endtask

    // Step to just after a tick edge so the next edge is the first one of a tick period.
    task automatic to_phase();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 4 != 0);
    endtask

    task automatic host_sync(input logic signed [31:0] t, input logic e);
        to_phase();
        tgt = t; en = e; syn = 1'b1;
        @(posedge clk);
        #1 syn = 1'b0;
    endtask

    task automatic set_error(input logic e);
        to_phase();
        err = e;
    endtask

    task automatic sync_x(input logic [31:0] t);
        @(posedge clk);
        #1 tgt_x = t; en_x = 1'b1; syn_x = 1'b1;
        @(posedge clk);
        #1 syn_x = 1'b0;
    endtask

    function automatic obs_t now_m();
        return {vel, eno, at};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1 check("reset", now_m(), rmp, {32'd0, 1'b0, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Ramp up 0 -> 35.
        expect_m(0, 0, 0, "up_arm");
        expect_m(0, 1, 0, "up_en");
        for (int v = 10; v <= 30; v += 10) expect_m(v, 1, 0, "up_step");
        expect_m(35, 1, 1, "up_land");
        host_sync(35, 1'b1);
        drain_m(80, "up");

        // Reversal 35 -> -12 through zero.
        expect_m(35, 1, 0, "rev_arm");
        for (int v = 25; v >= -5; v -= 10) expect_m(v, 1, 0, "rev_step");
        expect_m(-12, 1, 1, "rev_land");
        host_sync(-12, 1'b1);
        drain_m(80, "rev");

        // Back to 35.
        expect_m(-12, 1, 0, "back_arm");
        for (int v = -2; v <= 28; v += 10) expect_m(v, 1, 0, "back_step");
        expect_m(35, 1, 1, "back_land");
        host_sync(35, 1'b1);
        drain_m(80, "back");

        // Disable: decelerate with en_out held, drop it one cycle after zero.
        expect_m(35, 1, 0, "dis_arm");
        for (int v = 25; v >= 5; v -= 10) expect_m(v, 1, 0, "dis_step");
        expect_m(0, 1, 1, "dis_zero");
        expect_m(0, 0, 1, "dis_en_off");
        host_sync(35, 1'b0);
        drain_m(80, "dis");

        // Ramp to 120 for the error case.
        expect_m(0, 0, 0, "to120_arm");
        expect_m(0, 1, 0, "to120_en");
        for (int v = 10; v <= 110; v += 10) expect_m(v, 1, 0, "to120_step");
        expect_m(120, 1, 1, "to120_land");
        host_sync(120, 1'b1);
        drain_m(200, "to120");

        // Error: fast stop with the wider step, then en_out drops.
        expect_m(120, 1, 0, "err_arm");
        expect_m(70, 1, 0, "err_step");
        expect_m(20, 1, 0, "err_step");
        expect_m(0, 1, 1, "err_zero");
        expect_m(0, 0, 1, "err_en_off");
        set_error(1'b1);
        drain_m(80, "err");

        // Clearing error alone must not restart motion.
        set_error(1'b0);
        repeat (12) @(posedge clk);
        #1 check("err_clear_hold", now_m(), rmp, {32'd0, 1'b0, 1'b1});

        // A sync during error is held and takes effect once error clears.
        set_error(1'b1);
        host_sync(35, 1'b1);
        repeat (8) @(posedge clk);
        #1 check("err_sync_hold", now_m(), rmp, {32'd0, 1'b0, 1'b1});
        expect_m(0, 0, 0, "rearm_arm");
        expect_m(0, 1, 0, "rearm_en");
        expect_m(10, 1, 0, "rearm_step");
        expect_m(20, 1, 0, "rearm_step");
        set_error(1'b0);
        drain_m(80, "rearm");

        // Asynchronous reset mid-ramp at velocity 20.
        expect_m(0, 0, 1, "rst_async");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid", now_m(), rmp, {32'd0, 1'b0, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("rst_release_hold", now_m(), rmp, {32'd0, 1'b0, 1'b1});
        drain_m(10, "rst");

        // Extremes: full negative target, then full positive target.
        expect_x(32'h0000_0000, 0, 0, "ext_arm");
        expect_x(32'hC000_0000, 1, 0, "ext_neg_step");
        expect_x(32'h8000_0000, 1, 1, "ext_neg_land");
        sync_x(32'h8000_0000);
        drain_x(20, "ext_neg");

        expect_x(32'h8000_0000, 1, 0, "ext_pos_arm");
        expect_x(32'hC000_0000, 1, 0, "ext_pos_step");
        expect_x(32'h0000_0000, 1, 0, "ext_pos_step");
        expect_x(32'h4000_0000, 1, 0, "ext_pos_step");
        expect_x(32'h7FFF_FFFF, 1, 1, "ext_pos_land");
        sync_x(32'h7FFF_FFFF);
        drain_x(20, "ext_pos");

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
